// File: rtl/lift_pkg.sv
// Shared types and helpers for the lift car controller.
// Car state, floor code width and the ahead/behind mask helper.
package lift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR
    } state_t;

    localparam int FLOOR_W = 4;
    localparam int MASK_W  = 1 << FLOOR_W;

    // Floors strictly above fl when up=1, strictly below when up=0.
    function automatic logic [MASK_W-1:0] side_mask(
        input logic [FLOOR_W-1:0] fl,
        input logic               up
    );
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (up) m[i] = (i > int'(fl));
            else    m[i] = (i < int'(fl));
        end
        return m;
    endfunction

endpackage

// File: rtl/lift_if.sv
// Call inputs and car status outputs of the lift controller.
// master drives calls and watches status; slave is the controller.
interface lift_if #(
    parameter int N_FLOORS = 8
) ();

    logic [N_FLOORS-1:0]          call_req;
    logic [lift_pkg::FLOOR_W-1:0] floor;
    logic                         dir_up;
    logic                         moving;
    logic                         door_open;
    logic [N_FLOORS-1:0]          pending;

    modport master (
        output call_req,
        input  floor, dir_up, moving, door_open, pending
    );

    modport slave (
        input  call_req,
        output floor, dir_up, moving, door_open, pending
    );

endinterface

// File: rtl/lift_timer.sv
// Up-counter shared by travel and door phases.
// Reloads to 0 on start; done pulses when the count hits i_last.
module lift_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    // Count while enabled; every state entry restarts from zero.
    always_ff @(posedge clk) begin
        if (rst)          r_cnt <= '0;
        else if (i_start) r_cnt <= '0;
        else if (i_en)    r_cnt <= r_cnt + 1'b1;
    end

    assign o_done = i_en && (r_cnt == i_last);

endmodule

// File: rtl/lift_ctrl.sv
// Lift car controller: latches calls, moves one floor per travel
// period in SCAN order and holds the door open at served floors.
module lift_ctrl
    import lift_pkg::*;
#(
    parameter int N_FLOORS      = 8,
    parameter int TRAVEL_CYCLES = 50_000_000,
    parameter int DOOR_CYCLES   = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    lift_if.slave bus
);

    localparam int MAX_C = (TRAVEL_CYCLES > DOOR_CYCLES) ?
                           TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW    = $clog2(MAX_C + 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

    state_t               r_state;
    state_t               w_next;
    logic [FLOOR_W-1:0]   r_floor;
    logic [FLOOR_W-1:0]   w_floor_nx;
    logic [FLOOR_W-1:0]   w_step;
    logic [FLOOR_W-1:0]   w_eval;
    logic                 r_dir_up;
    logic                 w_dir_nx;
    logic                 r_moving;
    logic                 r_door;
    logic [N_FLOORS-1:0]  r_pending;
    logic [N_FLOORS-1:0]  w_req;
    logic [N_FLOORS-1:0]  w_clear;
    logic [MASK_W-1:0]    w_req_x;
    logic [MASK_W-1:0]    w_call_x;
    logic                 w_here;
    logic                 w_ahead;
    logic                 w_behind;
    logic                 w_arrive;
    logic                 w_start;
    logic                 w_done;
    logic [TW-1:0]        w_last;

    assign w_req    = r_pending | bus.call_req;
    assign w_req_x  = MASK_W'(w_req);
    assign w_call_x = MASK_W'(bus.call_req);
    assign w_step   = r_dir_up ? r_floor + 4'd1 : r_floor - 4'd1;
    assign w_arrive = (r_state == MOVE) && w_done;
    // Decisions on arrival look at the floor being stepped onto.
    assign w_eval   = w_arrive ? w_step : r_floor;
    assign w_here   = w_req_x[w_eval];
    assign w_ahead  = |(w_req_x & side_mask(w_eval, r_dir_up));
    assign w_behind = |(w_req_x & side_mask(w_eval, ~r_dir_up));
    assign w_last   = (r_state == MOVE) ? TRAVEL_LAST : DOOR_LAST;

    lift_timer #(
        .W       (TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_en    (r_state != IDLE),
        .i_last  (w_last),
        .o_done  (w_done)
    );

    // Next state, floor step, direction flip and timer restarts.
    always_comb begin
        w_next     = r_state;
        w_floor_nx = r_floor;
        w_dir_nx   = r_dir_up;
        w_start    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_here) begin
                    w_next  = DOOR;
                    w_start = 1'b1;
                end else if (w_ahead) begin
                    w_next  = MOVE;
                    w_start = 1'b1;
                end else if (w_behind) begin
                    w_dir_nx = ~r_dir_up;
                    w_next   = MOVE;
                    w_start  = 1'b1;
                end
            end
            MOVE: begin
                if (w_done) begin
                    w_floor_nx = w_step;
                    w_start    = 1'b1;
                    if (w_here)       w_next = DOOR;
                    else if (w_ahead) w_next = MOVE;
                    else              w_next = IDLE;
                end
            end
            DOOR: begin
                if (w_call_x[r_floor]) begin
                    w_start = 1'b1;
                end else if (w_done) begin
                    w_next  = IDLE;
                    w_start = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Served floor is cleared on DOOR entry and throughout DOOR.
    always_comb begin
        w_clear = '0;
        if (w_next == DOOR || r_state == DOOR) begin
            for (int i = 0; i < N_FLOORS; i++) begin
                w_clear[i] = (i == int'(w_eval));
            end
        end
    end

    // State, position and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_floor   <= '0;
            r_dir_up  <= 1'b1;
            r_moving  <= 1'b0;
            r_door    <= 1'b0;
            r_pending <= '0;
        end else begin
            r_state   <= w_next;
            r_floor   <= w_floor_nx;
            r_dir_up  <= w_dir_nx;
            r_moving  <= (w_next == MOVE);
            r_door    <= (w_next == DOOR);
            r_pending <= (r_pending | bus.call_req) & ~w_clear;
        end
    end

    assign bus.floor     = r_floor;
    assign bus.dir_up    = r_dir_up;
    assign bus.moving    = r_moving;
    assign bus.door_open = r_door;
    assign bus.pending   = r_pending;

endmodule

// File: tb/tb_lift_ctrl.sv
// Directed bench for lift_ctrl with a floor/door event scoreboard.
// Expected floor steps and door services are queued at stimulus time.
module tb_lift_ctrl;

    localparam int NF = 8;
    localparam int TC = 4;
    localparam int DC = 3;

    typedef struct {
        logic [3:0] fl;
        int         len;
    } door_ev_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    bit   mon_en;

    logic [3:0] floor_q[$];
    door_ev_t   door_q[$];

    lift_if #(.N_FLOORS(NF)) bus ();

    lift_ctrl #(
        .N_FLOORS      (NF),
        .TRAVEL_CYCLES (TC),
        .DOOR_CYCLES   (DC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic exp_floors(input int from, input int to);
        if (to > from) for (int f = from + 1; f <= to; f++) floor_q.push_back(4'(f));
        else           for (int f = from - 1; f >= to; f--) floor_q.push_back(4'(f));
    endtask

    task automatic exp_door(input int fl, input int len);
        door_ev_t e;
        e.fl  = 4'(fl);
        e.len = len;
        door_q.push_back(e);
    endtask

    task automatic pulse(input logic [NF-1:0] v);
        bus.call_req = v;
        tick();
        bus.call_req = '0;
    endtask

    task automatic drain(input string tag);
        int i;
        for (i = 0; i < 300; i++) begin
            if (door_q.size() == 0 && floor_q.size() == 0 &&
                !bus.moving && !bus.door_open) break;
            tick();
        end
        chk(tag, {bus.moving, bus.door_open,
                  16'(door_q.size()), 8'(floor_q.size())}, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk(tag, {bus.floor, bus.dir_up, bus.moving, bus.door_open,
                  bus.pending}, {4'd0, 1'b1, 1'b0, 1'b0, 8'd0});
    endtask

    // Scoreboard: floor steps and completed door services.
    logic [3:0] m_last_floor = '0;
    logic       m_last_door  = 1'b0;
    int         m_seg        = 0;
    int         m_door_len   = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.floor != m_last_floor) begin
                chk("step_len", m_seg, TC);
                m_seg = 0;
                chk("floor_expected", floor_q.size() > 0, 1);
                if (floor_q.size() > 0) chk("floor_seq", bus.floor, floor_q.pop_front());
            end
            if (bus.moving) m_seg++;
            if (bus.door_open) m_door_len++;
            if (m_last_door && !bus.door_open) begin
                chk("door_expected", door_q.size() > 0, 1);
                if (door_q.size() > 0) begin
                    door_ev_t e;
                    e = door_q.pop_front();
                    chk("door_floor", bus.floor, e.fl);
                    chk("door_len", m_door_len, e.len);
                end
                m_door_len = 0;
            end
            m_last_floor = bus.floor;
            m_last_door  = bus.door_open;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pm;
        int   i;
        n_pass       = 0;
        n_total      = 0;
        mon_en       = 1'b0;
        rst          = 1'b1;
        bus.call_req = '0;
        tick();
        tick();
        rst = 1'b0;

        for (int k = 0; k < 20; k++) begin
            tick();
            chk_reset_vals("idle_reset");
        end
        mon_en = 1'b1;

        exp_floors(0, 3);
        exp_door(3, DC);
        pulse(8'h08);
        chk("call3_moving", {bus.moving, bus.floor, bus.pending},
            {1'b1, 4'd0, 8'h08});
        pm = 1'b0;
        for (i = 0; i < 100 && !bus.door_open; i++) begin
            pm = bus.moving;
            tick();
        end
        chk("call3_door_rise", bus.door_open, 1);
        chk("call3_no_gap", pm, 1);
        chk("call3_arrive", {bus.floor, bus.pending, bus.moving},
            {4'd3, 8'h00, 1'b0});
        for (i = 0; i < 20 && bus.door_open; i++) tick();
        chk("call3_idle_gap", {bus.moving, bus.door_open}, 0);
        drain("call3_drain");

        exp_floors(3, 5);
        exp_door(5, DC);
        exp_floors(5, 1);
        exp_door(1, DC);
        pulse(8'h20);
        pulse(8'h02);
        chk("scan_pending", {bus.pending, bus.floor, bus.moving},
            {8'h22, 4'd3, 1'b1});
        for (i = 0; i < 100 && !(bus.door_open && bus.floor == 4'd5); i++) tick();
        chk("scan_door5", {bus.door_open, bus.floor}, {1'b1, 4'd5});
        for (i = 0; i < 20 && bus.door_open; i++) tick();
        chk("scan_gap", {bus.moving, bus.door_open, bus.dir_up}, 3'b001);
        tick();
        chk("scan_reverse", {bus.moving, bus.dir_up}, 2'b10);
        drain("scan_drain");

        exp_floors(1, 2);
        exp_door(2, DC + 2);
        pulse(8'h04);
        for (i = 0; i < 100 && !bus.door_open; i++) tick();
        chk("restart_door", {bus.door_open, bus.floor}, {1'b1, 4'd2});
        tick();
        pulse(8'h04);
        chk("restart_pending", {bus.pending, bus.door_open}, {8'h00, 1'b1});
        drain("restart_drain");

        exp_floors(2, 4);
        exp_door(4, DC);
        pulse(8'h10);
        drain("to4_drain");
        exp_floors(4, 7);
        exp_door(7, DC);
        exp_floors(7, 0);
        exp_door(0, DC);
        pulse(8'h81);
        chk("both_pending", {bus.pending, bus.moving, bus.dir_up},
            {8'h81, 1'b1, 1'b1});
        drain("both_drain");

        exp_floors(0, 5);
        pulse(8'h40);
        for (i = 0; i < 100 && bus.floor != 4'd5; i++) tick();
        tick();
        chk("pre_rst", {bus.floor, bus.moving, bus.pending},
            {4'd5, 1'b1, 8'h40});
        mon_en = 1'b0;
        rst    = 1'b1;
        tick();
        chk_reset_vals("mid_rst");
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_reset_vals("post_rst");
        end
        chk("queues_empty", door_q.size() + floor_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lift_ctrl.md
# lift_ctrl

Elevator car controller for the lift board project. Latches floor-call buttons and moves the car one floor at a time with a fixed travel time per floor. Serves requests in SCAN (collective) order and holds the door open for a fixed time at each served floor. Its registered `floor` output is the 4-bit binary code that drives the board-level 7-segment decoder directly.

## Interface
Parameters:
- `N_FLOORS`, 8: number of floors, numbered 0..N_FLOORS-1; legal range 2..16.
- `TRAVEL_CYCLES`, 50_000_000: clock cycles per one-floor move (1 s at 50 MHz); must be ≥1.
- `DOOR_CYCLES`, 100_000_000: clock cycles the door stays open; must be ≥1.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: reset, synchronous, active-high.
- `call_req` in N_FLOORS: one bit per floor; already debounced and synchronised; any cycle high registers a call.
- `floor` out 4: current car floor, binary, to the 7-segment decoder.
- `dir_up` out 1: 1 = current/last direction is up.
- `moving` out 1: high while the car is travelling between floors.
- `door_open` out 1: high while the door is open.
- `pending` out N_FLOORS: latched, unserved calls.

## Operation
- Reset values: `floor`=0, `dir_up`=1, `moving`=0, `door_open`=0, `pending`=0, state IDLE, timer 0.
- `req = pending | call_req` is used for every decision, so a call acts in the cycle it arrives.
- `ahead` means any `req` bit above `floor` when `dir_up`=1, or below it when `dir_up`=0. `behind` is the opposite side.
- IDLE:
  - `req[floor]` → DOOR.
  - else `ahead` → MOVE.
  - else `behind` → toggle `dir_up`, → MOVE.
  - else stay in IDLE.
- MOVE: the timer counts TRAVEL_CYCLES. At terminal count, `floor` steps ±1. The next state is evaluated on the new floor:
  - `req[new]` → DOOR.
  - else `ahead` → MOVE, timer restarts.
  - else → IDLE.
- DOOR: the timer counts DOOR_CYCLES, then → IDLE.
  - A `call_req` for the current floor while in DOOR restarts the door timer and is not latched.
- Pending update each cycle: `pending <= (pending | call_req) & ~clear`.
  - `clear` is the one-hot of the floor at which the state enters DOOR, or of the current floor while in DOOR.
  - A bit being set and cleared in the same cycle resolves to clear.
- Calls for a floor the car is passing, or that lie behind the car, stay pending until the direction reverses. The car never stops mid-move.
- `floor` is bounded to 0..N_FLOORS-1 by the `ahead`/`behind` logic; no extra wrap logic is needed.
- Reset mid-operation aborts everything: next cycle all outputs return to reset values, and latched calls are lost.

## Timing
- All outputs are registered.
- A call in cycle t at IDLE gives `moving` or `door_open` high from cycle t+1.
- `moving` is high for exactly TRAVEL_CYCLES cycles per floor. `floor` updates on the same edge the timer terminates. Across consecutive floors `moving` stays high continuously.
- `door_open` is high for exactly DOOR_CYCLES cycles after the last restart. It goes high on the edge after arrival, with no gap from the `moving` fall.
- From DOOR to IDLE there is a 1-cycle IDLE before the next MOVE or DOOR, so `moving` and `door_open` are both low for one cycle.
- Timer width is `$clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)+1)`. The timer reloads to 0 on every state entry.

## Structure
- Shared package `lift_pkg`:
  - state enum {IDLE, MOVE, DOOR};
  - `FLOOR_W`=4;
  - a function returning the `ahead`/`behind` masks for a given floor and direction.
- One sub-module, `lift_timer`: a parameterised up-counter with `start`, terminal-count compare input and `done` pulse. It is shared by MOVE and DOOR through a muxed limit.
- All remaining logic (FSM, pending register, direction) lives in `lift_ctrl`. Target size is ~200 lines.

## Test plan
Bench parameters: N_FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=3.
- Reset, then idle 20 cycles → `floor`=0, `dir_up`=1, `moving`=0, `door_open`=0, `pending`=0 throughout.
- 1-cycle pulse `call_req[3]` at floor 0 → `moving` high next cycle for 12 cycles; `floor` reads 1,2,3 at 4-cycle steps; `door_open` high 3 cycles; `pending[3]` clears on arrival; returns to IDLE.
- Car moving up at floor 3, `pending` bits 1 and 5 set → serves floor 5 first (door 3 cycles), then `dir_up`→0 and serves floor 1.
- At floor 2 in DOOR, pulse `call_req[2]` in door cycle 2 → `door_open` lasts 3 cycles after the pulse (5 total); `pending[2]` stays 0.
- `call_req[0]` and `call_req[7]` together at floor 4 with `dir_up`=1 → floor 7 is served, then floor 0; floor 4 is passed without stopping.
- Assert `rst` during MOVE between floors 5 and 6 with `pending[6]` set → next cycle `floor`=0, `moving`=0, `pending`=0.
